// File: rtl/ffo_pkg.sv
// ffo_pkg: shared types and helpers for the find-first-one family.
//   ffo_mb_state_t : mask-builder FSM states (COLLECT, HOLD)
//   ffo_idx_w()    : index width for an N-bit mask, shared with the FFO encoder
package ffo_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } ffo_mb_state_t;

    function automatic int unsigned ffo_idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational index-to-one-hot decoder.
//   idx    [0:W-1] : bit index (numeric value)
//   onehot [0:N-1] : onehot[idx] = 1, ascending numbering
module onehot_dec #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 5
) (
    input  logic [0:W-1] idx,
    output logic [0:N-1] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot[i] = (idx == W'(i));
        end
    end

endmodule

// File: rtl/ffo_mask_builder.sv
// ffo_mask_builder: packs a stream of bit indices into an N-bit mask.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : index beat handshake
//   in_idx [0:W-1]        : index of the bit to set
//   in_last               : final beat of the frame
//   out_valid/out_ready   : completed-mask handshake
//   out_mask [0:N-1]      : accumulated mask, out_mask[i] set by index i
//   out_count [W:0]       : distinct bits set, 0..N
//   out_dup               : some index in the frame was repeated
module ffo_mask_builder
    import ffo_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned W = ffo_idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:W-1] in_idx,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:N-1] out_mask,
    output logic [W:0]   out_count,
    output logic         out_dup
);

    localparam logic [W:0] CNT_ONE = (W+1)'(1);

    ffo_mb_state_t state;
    logic [0:N-1]  acc;
    logic [W:0]    count;
    logic          dup;
    logic [0:N-1]  idx_onehot;
    logic          hit;

    onehot_dec #(
        .N (N),
        .W (W)
    ) u_dec (
        .idx    (in_idx),
        .onehot (idx_onehot)
    );

    // Duplicate test uses acc before this beat's update.
    assign hit = |(acc & idx_onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            acc   <= '0;
            count <= '0;
            dup   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        acc <= acc | idx_onehot;
                        if (hit) begin
                            dup <= 1'b1;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        dup   <= 1'b0;
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Outputs come only from registers or state decode.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign out_mask  = acc;
    assign out_count = count;
    assign out_dup   = dup;

endmodule

// File: tb/tb_ffo_mask_builder.sv
// tb_ffo_mask_builder: directed self-checking bench for ffo_mask_builder, N=32.
module tb_ffo_mask_builder;

    localparam int unsigned N = 32;
    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:W-1] in_idx;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [0:N-1] out_mask;
    logic [W:0]   out_count;
    logic         out_dup;

    int n_vec  = 0;
    int n_miss = 0;

    ffo_mask_builder #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lowest set position in ascending numbering, -1 if empty.
    function automatic int ffo(input logic [0:N-1] m);
        for (int i = 0; i < int'(N); i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [0:N-1] bit_mask(input int i);
        logic [0:N-1] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // Present one beat and wait for it to be taken; leaves in_valid high.
    task automatic beat(input int idx, input logic last);
        int t;
        in_valid = 1'b1;
        in_idx   = 5'(idx);
        in_last  = last;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("beat_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
        check({tag, "_val_after"}, 64'(out_valid), 64'd0);
    endtask

    logic [0:N-1] em;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;

        // 1: reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mask", 64'(out_mask), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_dup", 64'(out_dup), 64'd0);

        // 2: single beat 31
        beat(31, 1'b1); idle();
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        check("t2_mask", 64'(out_mask), 64'(bit_mask(31)));
        check("t2_count", 64'(out_count), 64'd1);
        check("t2_dup", 64'(out_dup), 64'd0);
        check("t2_ffo", 64'(ffo(out_mask)), 64'd31);
        drain("t2");

        // 3: 3,17,5 then 0 alone
        beat(3, 1'b0); beat(17, 1'b0); beat(5, 1'b1); idle();
        em = bit_mask(3) | bit_mask(5) | bit_mask(17);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_mask", 64'(out_mask), 64'(em));
        check("t3_count", 64'(out_count), 64'd3);
        check("t3_dup", 64'(out_dup), 64'd0);
        check("t3_ffo", 64'(ffo(out_mask)), 64'd3);
        drain("t3");
        beat(0, 1'b1); idle();
        check("t3b_mask", 64'(out_mask), 64'(bit_mask(0)));
        check("t3b_count", 64'(out_count), 64'd1);
        check("t3b_dup", 64'(out_dup), 64'd0);
        drain("t3b");

        // 4: duplicate 7,7,2
        beat(7, 1'b0); beat(7, 1'b0); beat(2, 1'b1); idle();
        em = bit_mask(2) | bit_mask(7);
        check("t4_mask", 64'(out_mask), 64'(em));
        check("t4_count", 64'(out_count), 64'd2);
        check("t4_dup", 64'(out_dup), 64'd1);
        drain("t4");

        // 5: backpressure with a pending index-9 beat
        beat(1, 1'b0); beat(6, 1'b1);
        in_valid = 1'b1; in_idx = 5'd9; in_last = 1'b1;
        em = bit_mask(1) | bit_mask(6);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t5_hold_rdy", 64'(in_ready), 64'd0);
            check("t5_hold_val", 64'(out_valid), 64'd1);
            check("t5_hold_mask", 64'(out_mask), 64'(em));
            check("t5_hold_cnt", 64'(out_count), 64'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_back_rdy", 64'(in_ready), 64'd1);
        check("t5_back_mask", 64'(out_mask), 64'd0);
        @(posedge clk); #1;
        idle();
        check("t5_9_valid", 64'(out_valid), 64'd1);
        check("t5_9_mask", 64'(out_mask), 64'(bit_mask(9)));
        check("t5_9_count", 64'(out_count), 64'd1);
        drain("t5");

        // 6: full sweep
        for (int i = 0; i < 32; i++) beat(i, (i == 31));
        idle();
        check("t6_mask", 64'(out_mask), 64'hFFFF_FFFF);
        check("t6_count", 64'(out_count), 64'd32);
        check("t6_dup", 64'(out_dup), 64'd0);
        drain("t6");

        // 6b: reset mid-frame after beat 10
        for (int i = 0; i <= 10; i++) beat(i, 1'b0);
        idle();
        check("t6b_pre_count", 64'(out_count), 64'd11);
        rst_n = 1'b0;
        #2;
        check("t6b_rst_rdy", 64'(in_ready), 64'd1);
        check("t6b_rst_val", 64'(out_valid), 64'd0);
        check("t6b_rst_mask", 64'(out_mask), 64'd0);
        check("t6b_rst_count", 64'(out_count), 64'd0);
        check("t6b_rst_dup", 64'(out_dup), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(4, 1'b1); idle();
        check("t6c_valid", 64'(out_valid), 64'd1);
        check("t6c_mask", 64'(out_mask), 64'(bit_mask(4)));
        check("t6c_count", 64'(out_count), 64'd1);
        drain("t6c");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ffo_mask_builder.md
# ffo_mask_builder

Sequential index-to-mask packer: the inverse of the find-first-one encoder. Accepts a stream of bit indices over a valid/ready handshake, one index per beat, and sets the matching bit of an N-bit accumulator. On the beat flagged `in_last`, it presents the completed mask downstream with a population count and a duplicate flag. Used to rebuild request/grant vectors from encoded indices, so that FFO(`out_mask`) round-trips against the stream.

## Interface
- `N`, default 32: mask width; must be a power of two, N ≥ 2.
- `W`, default $clog2(N): index width; derived, not overridden.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: index beat valid.
- `in_ready` output 1: builder can accept a beat.
- `in_idx` input [0:W-1]: bit index to set.
- `in_last` input 1: final beat of the frame.
- `out_valid` output 1: completed mask available.
- `out_ready` input 1: downstream accepts the mask.
- `out_mask` output [0:N-1]: accumulated mask; index i sets `out_mask[i]`, in ascending [0:N-1] numbering.
- `out_count` output [W:0]: number of distinct bits set, range 0..N.
- `out_dup` output 1: at least one index in the frame was already set.

## Operation
- Two-state FSM: COLLECT and HOLD.
- COLLECT:
  - `in_ready`=1 and `out_valid`=0.
  - A beat is accepted when `in_valid`=1, which sets `acc[in_idx]`.
  - If that bit was previously 0, `count` increments. If it was already 1, `dup` is set (sticky for the frame) and `count` is unchanged.
  - An accepted beat with `in_last`=1 moves the FSM to HOLD.
- HOLD:
  - `in_ready`=0 and `out_valid`=1.
  - `out_mask`, `out_count` and `out_dup` hold stable.
  - When `out_ready`=1, the FSM clears `acc`, `count` and `dup` and returns to COLLECT.
- Beats presented in HOLD are not accepted. The upstream source must keep `in_valid` and `in_idx` stable until `in_ready` is 1.
- A frame is at least one beat. There is no empty-frame output.
- All N bits set gives `out_count`=N, which is why `out_count` is W+1 bits.
- The mask reflects only the current frame; nothing carries over between frames.
- `out_mask` is driven directly from `acc` at all times, but is meaningful only while `out_valid`=1.

## Timing
- Reset values (asynchronous on `rst_n` low, any cycle, including mid-frame or in HOLD):
  - State is COLLECT.
  - `acc`, `count` and `dup` are 0.
  - Outputs are therefore `in_ready`=1, `out_valid`=0, `out_mask`=0, `out_count`=0, `out_dup`=0.
  - A partial frame is discarded.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, so the mask includes the last index.
- Throughput:
  - One beat per cycle in COLLECT.
  - The HOLD handshake costs at least one cycle, so a k-beat frame occupies at least k+1 cycles.
- `out_ready` held high in HOLD: the FSM returns to COLLECT on the next edge, and `in_ready`=1 in the following cycle.
- Duplicate detection compares against `acc` before that beat's update.

## Structure
- Package `ffo_pkg` holds:
  - The FSM state enum `ffo_mb_state_t` (COLLECT, HOLD).
  - A localparam-style helper function for the index width, shared with the FFO encoder.
- Sub-module `onehot_dec`:
  - Combinational decoder from `in_idx` to an N-bit one-hot vector, in [0:N-1] ordering.
  - The builder ORs it into `acc` and ANDs it with `acc` for duplicate detection.
- Everything else lives in `ffo_mask_builder`: FSM, accumulator, counter and sticky flag.

## Test plan
All scenarios use N=32.
1. Assert `rst_n`=0 for 3 cycles, then release -> `in_ready`=1, `out_valid`=0, `out_mask`=0, `out_count`=0, `out_dup`=0.
2. Single beat `in_idx`=31 with `in_last`=1 -> next cycle: `out_valid`=1, only `out_mask[31]` set, `out_count`=1, `out_dup`=0, FFO(`out_mask`)=31.
3. Beats 3, 17, 5 (last) back-to-back -> bits 3, 5 and 17 set, `out_count`=3, `out_dup`=0. Then beats 0 (last) after `out_ready` -> only bit 0 set, proving the previous frame was cleared.
4. Beats 7, 7, 2 (last) -> bits 2 and 7 set, `out_count`=2, `out_dup`=1.
5. Backpressure: after the last beat, hold `out_ready`=0 for 5 cycles while `in_valid`=1 with `in_idx`=9 -> outputs stay stable and `in_ready`=0. Raise `out_ready` -> the index-9 beat is accepted starting in the cycle after the return to COLLECT.
6. Stream indices 0..31 (31 last) -> `out_mask` all ones, `out_count`=32. Repeat, but pull `rst_n` low after beat 10 -> all outputs return to their reset values, and a following frame of 4 (last) yields only bit 4 set.
